// File: rtl/video_pll_pkg.sv
// Shared types and constants for the video PLL power-up/recovery sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_pll_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_RETRY_MAX           = 3;

    // Width of a counter that must hold 0 .. max_count-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_count);
        cnt_width = (max_count <= 1) ? 1 : $clog2(max_count);
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL locked flag into refclk.
// Latency: 2 clk edges from input change to output change.
// Backpressure: none; free-running level synchronizer, resets to 0.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the raw input through the two stages.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Synchronizer stages with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/video_pll_sequencer.sv
// Sequences the video PLL reset, qualifies lock, releases the video reset, retries and parks in FAULT.
// Latency: outputs registered from next state; pll_locked edge reaches the FSM after 2 sync edges.
// Backpressure: none; restart_req accepted only in RUN/FAULT (acked next cycle), ignored elsewhere.
module video_pll_sequencer
    import video_pll_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned RETRY_MAX           = DEF_RETRY_MAX
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       video_rst_n,
    output logic       ready,
    output logic       fault,
    output logic       restart_ack,
    output logic [7:0] lol_count
);

    localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 1);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    // The attempt that fails while retry holds this value is the last one allowed.
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(RETRY_MAX - 1);

    logic locked_s;

    pll_state_e         state_q,       state_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [RETRY_W-1:0] retry_q,       retry_d;
    logic [7:0]         lol_q,         lol_d;
    logic               pll_rst_q,     pll_rst_d;
    logic               video_rst_n_q, video_rst_n_d;
    logic               ready_q,       ready_d;
    logic               fault_q,       fault_d;
    logic               ack_q,         ack_d;

    pll_lock_sync u_lock_sync (
        .clk      (refclk),
        .rst_n    (rst_n),
        .async_in (pll_locked),
        .sync_out (locked_s)
    );

    // Next-state, counter and output decode; outputs follow the next state so they switch with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lol_d   = lol_q;
        ack_d   = 1'b0;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + RETRY_W'(1);
                    cnt_d   = '0;
                    state_d = (retry_q == RETRY_LAST) ? FAULT : RESET_PLL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    // A glitch restarts qualification but is not counted as a failed attempt.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Lock loss and restart may coincide: count the loss and still ack the request.
                if (!locked_s || restart_req) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end
                if (!locked_s && (lol_q != 8'hFF)) begin
                    lol_d = lol_q + 8'd1;
                end
                ack_d = restart_req;
            end
            FAULT: begin
                if (restart_req) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        pll_rst_d     = (state_d == RESET_PLL);
        video_rst_n_d = (state_d == RUN);
        ready_d       = (state_d == RUN);
        fault_d       = (state_d == FAULT);
    end

    // Single state/counter/output register bank with synchronous active-low reset.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q       <= RESET_PLL;
            cnt_q         <= '0;
            retry_q       <= '0;
            lol_q         <= '0;
            pll_rst_q     <= 1'b1;
            video_rst_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            lol_q         <= lol_d;
            pll_rst_q     <= pll_rst_d;
            video_rst_n_q <= video_rst_n_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
            ack_q         <= ack_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign video_rst_n = video_rst_n_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign restart_ack = ack_q;
    assign lol_count   = lol_q;

endmodule

// File: tb/tb_video_pll_sequencer.sv
// Directed bench for video_pll_sequencer with small parameters (4/8/32/3).
// Inputs change and outputs are sampled on the falling edge of refclk.
module tb_video_pll_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic       video_rst_n;
    logic       ready;
    logic       fault;
    logic       restart_ack;
    logic [7:0] lol_count;

    int checks = 0;
    int errors = 0;

    video_pll_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .RETRY_MAX           (3)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .video_rst_n (video_rst_n),
        .ready       (ready),
        .fault       (fault),
        .restart_ack (restart_ack),
        .lol_count   (lol_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Observed outputs: {pll_rst, video_rst_n, ready, fault, restart_ack, lol_count}
    logic [12:0] obs;
    assign obs = {pll_rst, video_rst_n, ready, fault, restart_ack, lol_count};

    // A run of n cycles with inputs held, each cycle compared against exp after its edge.
    typedef struct {
        int          n;
        logic        rst_n;
        logic        lk;
        logic        rq;
        logic [12:0] exp;
    } seg_t;

    localparam int NSEG = 19;
    seg_t tbl [NSEG];

    function automatic seg_t mk(input int n, input bit r, input bit l, input bit q,
                                input bit pr, input bit vr, input bit rd,
                                input bit fl, input bit ak, input int lol);
        seg_t s;
        s.n     = n;
        s.rst_n = r;
        s.lk    = l;
        s.rq    = q;
        s.exp   = {pr, vr, rd, fl, ak, 8'(lol)};
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk(name, 32'(ready), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1, "watchdog");
    end

    logic e_rst;
    logic e_flt;

    initial begin
        rst_n       = 1'b0;
        pll_locked  = 1'b0;
        restart_req = 1'b0;

        //              n  rst lk rq   prst vrn rdy flt ack lol
        tbl[0]  = mk(2,  0, 0, 0,  1, 0, 0, 0, 0, 0); // reset values
        tbl[1]  = mk(3,  1, 0, 0,  1, 0, 0, 0, 0, 0); // pll_rst pulse continues
        tbl[2]  = mk(5,  1, 0, 0,  0, 0, 0, 0, 0, 0); // WAIT_LOCK
        tbl[3]  = mk(1,  1, 0, 1,  0, 0, 0, 0, 0, 0); // restart ignored in WAIT_LOCK
        tbl[4]  = mk(4,  1, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(10, 1, 1, 0,  0, 0, 0, 0, 0, 0); // locked 10 cycles after fall; 3 + 8 to release
        tbl[6]  = mk(5,  1, 1, 0,  0, 1, 1, 0, 0, 0); // RUN
        tbl[7]  = mk(2,  1, 0, 0,  0, 1, 1, 0, 0, 0); // lock loss still in synchronizer
        tbl[8]  = mk(1,  1, 0, 0,  1, 0, 0, 0, 0, 1); // third edge: RESET_PLL, counted
        tbl[9]  = mk(3,  1, 0, 0,  1, 0, 0, 0, 0, 1);
        tbl[10] = mk(3,  1, 0, 0,  0, 0, 0, 0, 0, 1); // WAIT_LOCK
        tbl[11] = mk(3,  1, 1, 0,  0, 0, 0, 0, 0, 1); // into STABILIZE
        tbl[12] = mk(3,  1, 1, 0,  0, 0, 0, 0, 0, 1);
        tbl[13] = mk(2,  1, 0, 0,  0, 0, 0, 0, 0, 1); // 2-cycle glitch
        tbl[14] = mk(10, 1, 1, 0,  0, 0, 0, 0, 0, 1); // no pll_rst, stable count restarts
        tbl[15] = mk(2,  1, 1, 0,  0, 1, 1, 0, 0, 1); // released after full 8 again
        tbl[16] = mk(1,  1, 1, 1,  1, 0, 0, 0, 1, 1); // restart in RUN: ack
        tbl[17] = mk(3,  1, 1, 0,  1, 0, 0, 0, 0, 1);
        tbl[18] = mk(2,  1, 1, 0,  0, 0, 0, 0, 0, 1);

        // Normal bring-up, glitch in STABILIZE, lock loss and restart in RUN
        for (int i = 0; i < NSEG; i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                rst_n       = tbl[i].rst_n;
                pll_locked  = tbl[i].lk;
                restart_req = tbl[i].rq;
                tick();
                chk($sformatf("vec%0d.%0d", i, c), 32'(obs), 32'(tbl[i].exp));
            end
        end

        // Lock never arrives: three attempts, then FAULT
        rst_n = 1'b0; pll_locked = 1'b0; restart_req = 1'b0;
        tick();
        chk("timeout_reset", 32'(obs), 32'h1000);
        rst_n = 1'b1;
        for (int k = 1; k <= 115; k++) begin
            tick();
            e_rst = (k < 108) && ((k % 36) < 4);
            e_flt = (k >= 108);
            chk($sformatf("timeout_k%0d", k), 32'({pll_rst, video_rst_n, ready, fault}),
                32'({e_rst, 1'b0, 1'b0, e_flt}));
        end
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("fault_restart_ack", 32'({pll_rst, fault, restart_ack}), 32'b101);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("fault_repulse%0d", j), 32'({pll_rst, fault, restart_ack}),
                32'({(j < 3), 1'b0, 1'b0}));
        end

        // Repeated loss of lock in RUN: lol_count saturates
        rst_n = 1'b0; pll_locked = 1'b1;
        tick();
        rst_n = 1'b1;
        wait_ready("lol_bringup");
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            tick(); tick(); tick();
            chk($sformatf("lol_react%0d", i), 32'({ready, pll_rst}), 32'b01);
            chk($sformatf("lol_count%0d", i), 32'(lol_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            pll_locked = 1'b1;
            wait_ready($sformatf("lol_relock%0d", i));
        end

        // Restart and lock loss seen in the same cycle
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready("both_bringup");
        pll_locked = 1'b0;
        tick(); tick();
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("both_first", 32'({pll_rst, ready, restart_ack, lol_count}), 32'({3'b101, 8'd1}));
        tick();
        chk("both_second", 32'({pll_rst, ready, restart_ack, lol_count}), 32'({3'b100, 8'd1}));
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("both_single%0d", j), 32'({pll_rst, lol_count}), 32'({(j < 2), 8'd1}));
        end

        // Reset in STABILIZE, then a clean restart from RESET_PLL
        pll_locked = 1'b1;
        tick(); tick(); tick(); tick();
        chk("stab_not_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("midseq_reset", 32'(obs), 32'h1000);
        rst_n = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            tick();
            chk($sformatf("midseq_rerun%0d", j), 32'({pll_rst, ready}), 32'({(j <= 3), (j >= 13)}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
